alu_seq: RTL
============

# alu_seq

Registered, parametrised N-bit ALU with a start/done handshake. It extends the processor's 4-operation, 4-bit combinational ALU to any width, eight operations (adds XOR, logical shifts and an iterative multiply) and registered NZCV flags. It sits in the processor execute stage. The control unit raises `start` with operands and `ALU_Sel`, then waits on `done` before consuming `ALU_Result` and `ALU_Flags`.

## Interface
- `N`, default 8: operand and result width; N ≥ 4, power of two.
- `SW`, default $clog2(N): width of the shift amount taken from `B`.

Ports, clock and reset first:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled on a rising edge only while `busy`=0.
- `A` in N: operand A; latched when `start` is accepted.
- `B` in N: operand B; latched when `start` is accepted.
- `ALU_Sel` in 3: opcode; latched when `start` is accepted. 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- `ALU_Result` out N: registered result; held until the next `done`.
- `ALU_Flags` out 4: registered flags {N,Z,C,V}, with N = bit 3 and Z = bit 2. Updated only together with `ALU_Result`.
- `busy` out 1: high while a MUL is iterating.
- `done` out 1: one-cycle pulse marking a new valid `ALU_Result` and `ALU_Flags`.

## Operation
- States:
  - IDLE: `busy`=0.
  - MUL_RUN: `busy`=1. Holds iteration counter `cnt`, 0..N-1.
  - Transitions: IDLE → MUL_RUN on an accepted `start` with MUL. MUL_RUN → IDLE when `cnt`=N-1.
  - Single-cycle operations never leave IDLE.
- Arithmetic, all unsigned N-bit with wrap-around:
  - ADD: C = carry out of bit N-1; V = signed overflow (operands share a sign and the result sign differs).
  - SUB: computed as A + ~B + 1. C = 1 when there is no borrow (A ≥ B unsigned). V = signed overflow (operand signs differ and the result sign differs from A).
  - AND, OR, XOR: C=0, V=0.
  - SHL, SHR: shift amount = B[SW-1:0]; upper bits of B are ignored. C = last bit shifted out; C=0 when the amount is 0. V=0.
  - MUL: radix-2 shift-add over N iterations, using a 2N-bit accumulator. Result = low N bits. C = 1 if the high N bits are nonzero (unsigned overflow). V=0.
- Every operation: N flag = result[N-1]; Z flag = (result == 0).
- Handshake:
  - `start` is accepted on any edge where `busy`=0, including the cycle in which `done` is high (back-to-back issue).
  - `start` while `busy`=1 is ignored: it is not queued and does not disturb the in-flight operands.
  - Operand or `ALU_Sel` changes after acceptance have no effect on the in-flight operation.
- Reset (asynchronous, any time including mid-MUL):
  - `ALU_Result`=0, `ALU_Flags`=0000, `busy`=0, `done`=0; state IDLE; `cnt`=0; accumulator cleared.
  - No `done` is produced for an aborted operation.
  - After `rst_n` is released, the first `start` is accepted normally.

## Timing
- Single-cycle operations: `start` accepted at edge E0. Result, flags and `done`=1 are registered at E0 and visible in the cycle following E0. Latency is 1 cycle.
- MUL: `start` accepted at E0.
  - `busy`=1 from E0 through edge E_N, i.e. exactly N cycles.
  - Result, flags and `done` are registered at E_N; `busy`=0 in the same cycle.
  - Latency is N cycles; for N=8, `done` appears 8 cycles after the start edge.
- `done` is high for exactly one cycle per accepted request and is never high while `busy`=1.
- Outputs change only on the `done` edge or on reset; there is no combinational path from inputs to outputs.

## Test plan
- N=8, ADD A=0x7F B=0x01 → `ALU_Result`=0x80, `ALU_Flags`=1001; `done` pulses one cycle after start; `busy` stays 0.
- SUB A=0x01 B=0x03 → 0xFE, flags 1000. Then, back-to-back on the `done` cycle, SUB 0x05−0x05 → 0x00, flags 0110.
- SHL A=0x81 B=0x09 (amount 1) → 0x02, flags 0010. SHR A=0x01 B=0x00 → 0x01, flags 0000.
- MUL A=0x10 B=0x10 → 0x00, flags 0110; `busy` high for exactly 8 cycles; `done` 8 cycles after start. A `start` with ADD 1+1 issued mid-run is ignored: exactly one `done`, and the result stays 0x00.
- MUL A=0x0F B=0x0F → 0xE1, flags 1000. XOR 0xAA^0xAA → 0x00, flags 0100.
- Deassert `rst_n` during cycle 4 of a MUL → all outputs 0 immediately with no clock edge; after release, ADD 3+1 → 0x04, flags 0000, after 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// Registered N-bit ALU with start/done handshake: single-cycle logic/arith/shift ops
// plus an N-cycle radix-2 shift-add multiply, with registered NZCV flags.
module alu_seq #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   ALU_Sel,
  output logic [N-1:0] ALU_Result,
  output logic [3:0]   ALU_Flags,
  output logic         busy,
  output logic         done
);

  // Handshake: start is taken on any rising edge with busy=0 (including the done
  // cycle); start while busy=1 is dropped. done is a one-cycle pulse per request.

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE, S_MUL_RUN} state_t;

  state_t         r_state;
  logic [SW-1:0]  r_cnt;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplier;
  logic [N-1:0]   r_result;
  logic [3:0]     r_flags;
  logic           r_busy;
  logic           r_done;

  logic [SW-1:0]  w_shamt;
  logic [N:0]     w_add;
  logic [N:0]     w_sub;
  logic [N:0]     w_shl;
  logic [N:0]     w_shr;
  logic [N-1:0]   w_res;
  logic           w_c;
  logic           w_v;
  logic [2*N-1:0] w_acc_next;
  logic           w_mul_hi;

  always_comb begin
    w_shamt = B[SW-1:0];
    w_add   = {1'b0, A} + {1'b0, B};
    w_sub   = {1'b0, A} + {1'b0, ~B} + (N+1)'(1);
    // The extra bit catches the last bit shifted out; it is 0 for a zero amount.
    w_shl   = {1'b0, A} << w_shamt;
    w_shr   = {A, 1'b0} >> w_shamt;
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    case (ALU_Sel)
      OP_ADD: begin
        w_res = w_add[N-1:0];
        w_c   = w_add[N];
        w_v   = (A[N-1] == B[N-1]) && (w_res[N-1] != A[N-1]);
      end
      OP_SUB: begin
        w_res = w_sub[N-1:0];
        w_c   = w_sub[N];
        w_v   = (A[N-1] != B[N-1]) && (w_res[N-1] != A[N-1]);
      end
      OP_AND: w_res = A & B;
      OP_OR:  w_res = A | B;
      OP_XOR: w_res = A ^ B;
      OP_SHL: begin
        w_res = w_shl[N-1:0];
        w_c   = w_shl[N];
      end
      OP_SHR: begin
        w_res = w_shr[N:1];
        w_c   = w_shr[0];
      end
      default: w_res = '0;
    endcase
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_mul_hi   = |w_acc_next[2*N-1:N];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (ALU_Sel == OP_MUL) begin
              r_state  <= S_MUL_RUN;
              r_busy   <= 1'b1;
              r_cnt    <= '0;
              r_acc    <= '0;
              r_mcand  <= {{N{1'b0}}, A};
              r_mplier <= B;
            end else begin
              r_result <= w_res;
              r_flags  <= {w_res[N-1], (w_res == '0), w_c, w_v};
              r_done   <= 1'b1;
            end
          end
        end
        S_MUL_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == SW'(N-1)) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_cnt    <= '0;
            r_result <= w_acc_next[N-1:0];
            r_flags  <= {w_acc_next[N-1], (w_acc_next[N-1:0] == '0), w_mul_hi, 1'b0};
          end else begin
            r_cnt <= r_cnt + SW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ALU_Result = r_result;
  assign ALU_Flags  = r_flags;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
